// File: rtl/normal_update_scheduler.sv
// normal_update_scheduler
// Decides when the one-cycle UPDATE strobe to the transducer duty/phase/delay
// loader fires. Loads are aligned to the carrier-cycle boundary (SYNC_TICK),
// a FORCE_REQ bypasses that alignment, and the loader is never re-triggered
// before LOAD_CYCLES have elapsed since the previous strobe.
//
// Optional build macro: SYNC_TIMEOUT_EN
//   defined   : ARMED fires on its own after TIMEOUT_CYCLES un-held cycles
//               without a SYNC_TICK, and TIMEOUT_FLAG records it (sticky).
//   undefined : ARMED waits indefinitely; TIMEOUT_FLAG is constant 0 and no
//               wait counter exists.
//
// Handshake: UPDATE_REQ, FORCE_REQ and SYNC_TICK are single-cycle pulses with
// no back-pressure; a pulse is consumed in the cycle it is high and is never
// refused (it is queued or merged). UPDATE is a single-cycle strobe with no
// acknowledge; the loader is assumed busy for LOAD_CYCLES cycles after it.
//
// Observable timing: a decision taken in cycle t shows on the outputs in
// cycle t+1. BUSY reports the state the block was in during the previous
// cycle, so the cycle carrying UPDATE always shows BUSY low.
module normal_update_scheduler #(
    parameter int LOAD_CYCLES    = 504,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        UPDATE_REQ,
    input  logic        FORCE_REQ,
    input  logic        SYNC_TICK,
    input  logic        HOLD,
    output logic        UPDATE,
    output logic        BUSY,
    output logic        PENDING,
    output logic [15:0] UPDATE_CNT,
    output logic [7:0]  DROP_CNT,
    output logic        TIMEOUT_FLAG
);

    localparam int CW = $clog2(LOAD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_RELOAD = CW'(LOAD_CYCLES - 1);

    typedef enum logic [1:0] {
        GUARD = 2'd0,
        IDLE  = 2'd1,
        ARMED = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          force_flag;

    logic          req;
    logic          drop_sat;
    logic          timeout_hit;
    logic          fire;

    // Any request pulse, plain or forced, is one request for queueing purposes.
    assign req      = UPDATE_REQ | FORCE_REQ;
    assign drop_sat = (DROP_CNT == 8'hFF);

`ifdef SYNC_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == WW'(TIMEOUT_CYCLES));

    // Counts un-held cycles spent in ARMED; zero on every ARMED entry.
    always_ff @(posedge CLK) begin
        if (RST || (state != ARMED) || fire) begin
            wait_cnt <= '0;
        end else if (!HOLD) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end
`else
    logic unused_timeout_param;

    assign timeout_hit          = 1'b0;
    assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
    assign TIMEOUT_FLAG         = 1'b0;
`endif

    // A queued request fires only from ARMED, never while HOLD is high.
    // A SYNC_TICK arriving during HOLD is simply lost.
    assign fire = (state == ARMED) && !HOLD &&
                  (force_flag || SYNC_TICK || timeout_hit);

    // Scheduler state machine with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // GUARD drains a load that may still be in flight: the loader
            // has no reset of its own.
            state      <= GUARD;
            cnt        <= LOAD_RELOAD;
            UPDATE     <= 1'b0;
            BUSY       <= 1'b1;
            PENDING    <= 1'b0;
            force_flag <= 1'b0;
            UPDATE_CNT <= 16'd0;
            DROP_CNT   <= 8'd0;
`ifdef SYNC_TIMEOUT_EN
            TIMEOUT_FLAG <= 1'b0;
`endif
        end else begin
            UPDATE <= 1'b0;
            BUSY   <= (state == GUARD) || (state == LOAD);

            case (state)
                GUARD, LOAD: begin
                    // Loader is (or may be) busy: queue requests, merge extras.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (req) begin
                        PENDING <= 1'b1;
                        if (FORCE_REQ) begin
                            force_flag <= 1'b1;
                        end
                        if (PENDING && !drop_sat) begin
                            DROP_CNT <= DROP_CNT + 8'd1;
                        end
                    end
                    if (cnt == '0) begin
                        state <= (PENDING || req) ? ARMED : IDLE;
                    end
                end

                IDLE: begin
                    // A SYNC_TICK in the request cycle is not used: the
                    // request only becomes eligible from the next cycle.
                    if (req) begin
                        PENDING    <= 1'b1;
                        force_flag <= FORCE_REQ;
                        state      <= ARMED;
                    end
                end

                ARMED: begin
                    if (fire) begin
                        UPDATE     <= 1'b1;
                        UPDATE_CNT <= UPDATE_CNT + 16'd1;
                        cnt        <= LOAD_RELOAD;
                        state      <= LOAD;
                        // A request landing on the fire cycle becomes the
                        // next pending one rather than a drop.
                        PENDING    <= req;
                        force_flag <= FORCE_REQ;
`ifdef SYNC_TIMEOUT_EN
                        if (timeout_hit && !force_flag && !SYNC_TICK) begin
                            TIMEOUT_FLAG <= 1'b1;
                        end
`endif
                    end else if (req) begin
                        if (!drop_sat) begin
                            DROP_CNT <= DROP_CNT + 8'd1;
                        end
                        if (FORCE_REQ) begin
                            force_flag <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= GUARD;
                    cnt   <= LOAD_RELOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normal_update_scheduler.sv
// Testbench for normal_update_scheduler (LOAD_CYCLES=16, TIMEOUT_CYCLES=32).
// Cycle numbering: cycle 0 is the last cycle with RST high. Inputs driven "in
// cycle t" are sampled at the clock edge ending cycle t; outputs observed "in
// cycle t" are those registered at the edge ending cycle t-1.
module tb_normal_update_scheduler;

    localparam int LOAD = 16;
    localparam int TO   = 32;

    logic        clk;
    logic        rst;
    logic        update_req;
    logic        force_req;
    logic        sync_tick;
    logic        hold;
    logic        update;
    logic        busy;
    logic        pending;
    logic [15:0] update_cnt;
    logic [7:0]  drop_cnt;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = -3;

    normal_update_scheduler #(
        .LOAD_CYCLES    (LOAD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .UPDATE_REQ   (update_req),
        .FORCE_REQ    (force_req),
        .SYNC_TICK    (sync_tick),
        .HOLD         (hold),
        .UPDATE       (update),
        .BUSY         (busy),
        .PENDING      (pending),
        .UPDATE_CNT   (update_cnt),
        .DROP_CNT     (drop_cnt),
        .TIMEOUT_FLAG (timeout_flag)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc + 1, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time-based view: the loader is unavailable before free_at; a queued
    // request may fire once the loader is free and the request is older than
    // the current cycle, on a forced flag, a tick, or a timeout.
    bit model_ok = 1'b0;
    int free_at, pend_since, frc_since;
    bit pend, frc;
    int ucnt, drops;
    bit tflag;
    bit exp_update, exp_busy;
`ifdef SYNC_TIMEOUT_EN
    int wait_n;
`endif

    always @(posedge clk) begin
        int  e;
        bit  busy_now, eligible, force_eff, to_fire, fire, req;
        cyc = cyc + 1;
        e   = cyc;
        req = update_req | force_req;
        if (rst) begin
            free_at    = e + 1 + LOAD;
            pend       = 1'b0;
            frc        = 1'b0;
            pend_since = e;
            frc_since  = e;
            ucnt       = 0;
            drops      = 0;
            tflag      = 1'b0;
            exp_update = 1'b0;
            exp_busy   = 1'b1;
`ifdef SYNC_TIMEOUT_EN
            wait_n     = 0;
`endif
            model_ok   = 1'b1;
        end else begin
            busy_now  = (e < free_at);
            eligible  = pend && !busy_now && (e > pend_since);
            force_eff = frc && (e > frc_since);
            to_fire   = 1'b0;
`ifdef SYNC_TIMEOUT_EN
            to_fire = eligible && !hold && (wait_n == TO);
`endif
            fire = eligible && !hold && (force_eff || sync_tick || to_fire);
`ifdef SYNC_TIMEOUT_EN
            if (!eligible || fire) wait_n = 0;
            else if (!hold) wait_n = wait_n + 1;
`endif
            exp_busy   = busy_now;
            exp_update = fire;
            if (fire) begin
                ucnt    = (ucnt + 1) % 65536;
                free_at = e + 1 + LOAD;
                if (to_fire && !force_eff && !sync_tick) tflag = 1'b1;
                pend       = req;
                pend_since = e;
                frc        = force_req;
                frc_since  = e;
            end else if (req) begin
                if (pend) begin
                    if (drops < 255) drops = drops + 1;
                end else begin
                    pend_since = e;
                end
                pend = 1'b1;
                if (force_req && !frc) begin
                    frc       = 1'b1;
                    frc_since = e;
                end
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            check("update",       int'(update),       int'(exp_update));
            check("busy",         int'(busy),         int'(exp_busy));
            check("pending",      int'(pending),      int'(pend));
            check("update_cnt",   int'(update_cnt),   ucnt);
            check("drop_cnt",     int'(drop_cnt),     drops);
            check("timeout_flag", int'(timeout_flag), int'(tflag));
        end
    end

    // ---------------- driver tasks ----------------
    // Advance to cycle t (negedge inside it); pulses last exactly one cycle.
    task automatic at_cycle(input int t);
        while (cyc < t - 1) begin
            @(negedge clk);
            update_req = 1'b0;
            force_req  = 1'b0;
            sync_tick  = 1'b0;
        end
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int busy_n;
        int upd_n;
        rst        = 1'b1;
        update_req = 1'b0;
        force_req  = 1'b0;
        sync_tick  = 1'b0;
        hold       = 1'b0;
        while (cyc < 0) @(negedge clk);
        rst = 1'b0;

        // Reset values, then the GUARD drain.
        at_cycle(1);
        check("rst_update",  int'(update), 0);
        check("rst_busy",    int'(busy), 1);
        check("rst_pending", int'(pending), 0);
        check("rst_ucnt",    int'(update_cnt), 0);
        check("rst_dcnt",    int'(drop_cnt), 0);
        check("rst_tflag",   int'(timeout_flag), 0);
        busy_n = 0;
        upd_n  = 0;
        for (int t = 2; t <= 21; t++) begin
            at_cycle(t);
            busy_n += int'(busy);
            upd_n  += int'(update);
        end
        check("guard_busy_len", busy_n, 16);
        check("guard_no_update", upd_n, 0);
        check("guard_busy_low_end", int'(busy), 0);

        // Request with a same-cycle tick; the next tick fires.
        at_cycle(30);
        update_req = 1'b1;
        sync_tick  = 1'b1;
        at_cycle(31);
        check("a_pending", int'(pending), 1);
        check("a_no_early_fire", int'(update), 0);
        at_cycle(40);
        sync_tick = 1'b1;
        at_cycle(41);
        check("a_update", int'(update), 1);
        check("a_ucnt", int'(update_cnt), 1);
        check("a_pending_clr", int'(pending), 0);
        check("a_busy_on_strobe", int'(busy), 0);
        busy_n = 0;
        for (int t = 42; t <= 58; t++) begin
            at_cycle(t);
            busy_n += int'(busy);
            if (t == 42) check("a_update_single", int'(update), 0);
        end
        check("a_busy_len", busy_n, 16);
        check("a_busy_low_58", int'(busy), 0);

        // Forced requests: immediate, then spaced by LOAD+1.
        at_cycle(100);
        force_req = 1'b1;
        at_cycle(102);
        check("b_force_update", int'(update), 1);
        at_cycle(105);
        force_req = 1'b1;
        at_cycle(118);
        check("b_no_early_118", int'(update), 0);
        at_cycle(119);
        check("b_force2_update", int'(update), 1);
        check("b_ucnt", int'(update_cnt), 3);
        check("b_no_drop", int'(drop_cnt), 0);

        // Three requests in one LOAD coalesce into one.
        at_cycle(122); update_req = 1'b1;
        at_cycle(125); update_req = 1'b1;
        at_cycle(128); update_req = 1'b1;
        at_cycle(129);
        check("c_drop2", int'(drop_cnt), 2);
        check("c_pending", int'(pending), 1);
        at_cycle(140); sync_tick = 1'b1;
        at_cycle(141);
        check("c_update", int'(update), 1);
        check("c_ucnt", int'(update_cnt), 4);
        check("c_pending_clr", int'(pending), 0);

        // HOLD masks ticks; first tick after HOLD falls fires.
        at_cycle(165); hold = 1'b1;
        at_cycle(170); update_req = 1'b1; sync_tick = 1'b1;
        at_cycle(180); sync_tick = 1'b1;
        at_cycle(190); sync_tick = 1'b1;
        at_cycle(191);
        check("d_held", int'(update), 0);
        at_cycle(195); hold = 1'b0;
        check("d_pending_held", int'(pending), 1);
        at_cycle(200); sync_tick = 1'b1;
        check("d_no_fire_200", int'(update), 0);
        at_cycle(201);
        check("d_update", int'(update), 1);
        check("d_ucnt", int'(update_cnt), 5);

        // Forced request under HOLD fires on the first un-held cycle.
        at_cycle(225); hold = 1'b1;
        at_cycle(230); force_req = 1'b1;
        at_cycle(240); hold = 1'b0;
        check("e_held", int'(update), 0);
        at_cycle(241);
        check("e_update", int'(update), 1);
        check("e_ucnt", int'(update_cnt), 6);

        // Request on the fire cycle is queued, not dropped.
        at_cycle(270); update_req = 1'b1;
        at_cycle(280); update_req = 1'b1; sync_tick = 1'b1;
        at_cycle(281);
        check("f_update", int'(update), 1);
        check("f_pending_kept", int'(pending), 1);
        check("f_no_drop", int'(drop_cnt), 2);
        at_cycle(300); sync_tick = 1'b1;
        at_cycle(301);
        check("f_update2", int'(update), 1);
        check("f_ucnt", int'(update_cnt), 8);

        // No SYNC_TICK at all after a request.
        at_cycle(330); update_req = 1'b1;
`ifdef SYNC_TIMEOUT_EN
        at_cycle(363);
        check("g_no_early_timeout", int'(update), 0);
        at_cycle(364);
        check("g_timeout_update", int'(update), 1);
        check("g_tflag", int'(timeout_flag), 1);
        check("g_ucnt", int'(update_cnt), 9);
        at_cycle(370); update_req = 1'b1;
        at_cycle(371);
        check("g_pending_in_load", int'(pending), 1);
        at_cycle(372); rst = 1'b1;
        at_cycle(373); rst = 1'b0;
        check("g_rst_tflag", int'(timeout_flag), 0);
        check("g_rst_pending", int'(pending), 0);
        check("g_rst_ucnt", int'(update_cnt), 0);
        check("g_rst_busy", int'(busy), 1);
        at_cycle(400);
`else
        upd_n = 0;
        for (int t = 331; t <= 1400; t++) begin
            at_cycle(t);
            upd_n += int'(update);
        end
        check("g_no_update_1000", upd_n, 0);
        check("g_ucnt", int'(update_cnt), 8);
        check("g_pending", int'(pending), 1);
        check("g_tflag_tied", int'(timeout_flag), 0);
        rst = 1'b1;
        at_cycle(1401); rst = 1'b0;
        check("g_rst_pending", int'(pending), 0);
        check("g_rst_busy", int'(busy), 1);
        at_cycle(1430);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
